// File: rtl/lsu_rmw.sv
// Load/store unit: turns byte/half/word RISC-V accesses into whole-word accesses
// on a single-port synchronous memory. Sub-word stores use read-modify-write.
module lsu_rmw #(
  parameter int WORD_AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               we,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WORD_AW-1:0] mem_addr,
  output logic               mem_we,
  output logic [31:0]        mem_wd,
  input  logic [31:0]        mem_rd
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_MERGE, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 we_q, we_d;
  logic [2:0]           f3_q, f3_d;
  logic [WORD_AW+1:0]   addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic [31:0]          rdata_q, rdata_d;

  // Address bits above the memory's reach are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:WORD_AW+2];

  function automatic logic access_illegal(input logic w, input logic [2:0] f3,
                                          input logic [1:0] a);
    logic bad_f3, misaligned;
    if (w) bad_f3 = (f3 >= 3'd3);
    else   bad_f3 = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    misaligned = ((f3[1:0] == 2'd1) && a[0]) || ((f3[1:0] == 2'd2) && (a != 2'd0));
    return bad_f3 || misaligned;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] r;
    r = old;
    case (f3[1:0])
      2'd0:    r[{a, 3'b000} +: 8] = wd[7:0];
      2'd1:    r[{a[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [2:0] f3,
                                               input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{a, 3'b000} +: 8];
    h = rd[{a[1], 4'b0000} +: 16];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          f3_d    = funct3;
          addr_d  = addr[WORD_AW+1:0];
          wdata_d = wdata;
          err_d   = access_illegal(we, funct3, addr[1:0]);
          if (err_d)                          state_d = S_DONE;
          else if (we && (funct3 == 3'd2))    state_d = S_MERGE;
          else                                state_d = S_READ;
        end
      end
      S_READ:  state_d = S_MERGE;
      S_MERGE: begin
        if (!we_q) rdata_d = load_extract(mem_rd, f3_q, addr_q[1:0]);
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Errored accesses never reach MERGE, so no error term is needed on the write enable.
  assign mem_we   = (state_q == S_MERGE) && we_q && !rst;
  assign mem_wd   = store_merge(mem_rd, wdata_q, f3_q, addr_q[1:0]);
  assign mem_addr = addr_q[WORD_AW+1:2];
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_DONE) && err_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a synchronous-read word memory model.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata, mem_wd, mem_rd;
  logic        busy, done, err, mem_we;
  logic [7:0]  mem_addr;

  logic        pre_we;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;
  logic [31:0] mem [256];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  lsu_rmw #(.WORD_AW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always @(posedge clk) begin
    if (pre_we)      mem[pre_a] <= pre_d;
    else if (mem_we) mem[mem_addr] <= mem_wd;
    mem_rd <= mem[mem_addr];
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;
    int          lat;
    logic        err;
    int          nwe;
    int          wecyc;
    logic [7:0]  midx;
    logic [31:0] mval;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              logic pe, logic [7:0] pi, logic [31:0] pv, int lat,
                              logic e, int nwe, int wc, logic [7:0] mi, logic [31:0] mv,
                              logic [31:0] rd);
    vec_t v;
    v.we = w; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.pre_en = pe; v.pre_idx = pi; v.pre_val = pv;
    v.lat = lat; v.err = e; v.nwe = nwe; v.wecyc = wc;
    v.midx = mi; v.mval = mv; v.rdata = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_a = idx; pre_d = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one access and observes it cycle by cycle; lat=0 means no done within budget.
  task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output int lat, output int nwe,
                     output int wecyc, output logic [7:0] ma, output logic e,
                     output logic bsy);
    lat = 0; nwe = 0; wecyc = 0; ma = 8'd0; e = 1'b0; bsy = 1'b0;
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) bsy = busy;
      if (mem_we) begin nwe++; wecyc = c; ma = mem_addr; end
      if (done) begin lat = c; e = err; break; end
      req = 1'b0; we = ~w; funct3 = ~f3; addr = ~a; wdata = ~wd;
    end
    req = 1'b0;
  endtask

  vec_t vt [19];

  initial begin
    int          lat, nwe, wecyc;
    logic [7:0]  ma;
    logic        e, bsy;

    vt[0]  = mk(1, 0, 20,  32'hdeadc0de, 1, 5,  32'h11223344, 3, 0, 1, 2, 5,  32'h112233de, 32'h0);
    vt[1]  = mk(1, 0, 23,  32'h000000ef, 1, 5,  32'h11223344, 3, 0, 1, 2, 5,  32'hef223344, 32'h0);
    vt[2]  = mk(1, 1, 22,  32'h0000beef, 0, 0,  32'h0,        3, 0, 1, 2, 5,  32'hbeef3344, 32'h0);
    vt[3]  = mk(1, 2, 40,  32'hc001c0de, 0, 0,  32'h0,        2, 0, 1, 1, 10, 32'hc001c0de, 32'h0);
    vt[4]  = mk(1, 2, 32'hfffff028, 32'h12345678, 0, 0, 32'h0, 2, 0, 1, 1, 10, 32'h12345678, 32'h0);
    vt[5]  = mk(0, 0, 46,  32'h0, 1, 11, 32'h80ff7f01, 3, 0, 0, 0, 11, 32'h80ff7f01, 32'hffffffff);
    vt[6]  = mk(0, 4, 46,  32'h0, 0, 0,  32'h0,        3, 0, 0, 0, 11, 32'h80ff7f01, 32'h000000ff);
    vt[7]  = mk(0, 1, 44,  32'h0, 0, 0,  32'h0,        3, 0, 0, 0, 11, 32'h80ff7f01, 32'h00007f01);
    vt[8]  = mk(0, 1, 46,  32'h0, 0, 0,  32'h0,        3, 0, 0, 0, 11, 32'h80ff7f01, 32'hffff80ff);
    vt[9]  = mk(0, 2, 44,  32'h0, 0, 0,  32'h0,        3, 0, 0, 0, 11, 32'h80ff7f01, 32'h80ff7f01);
    vt[10] = mk(1, 0, 45,  32'h00000055, 0, 0, 32'h0,  3, 0, 1, 2, 11, 32'h80ff5501, 32'h80ff7f01);
    vt[11] = mk(1, 2, 42,  32'hffffffff, 0, 0, 32'h0,  1, 1, 0, 0, 10, 32'h12345678, 32'h80ff7f01);
    vt[12] = mk(1, 1, 21,  32'hffffffff, 0, 0, 32'h0,  1, 1, 0, 0, 5,  32'hbeef3344, 32'h80ff7f01);
    vt[13] = mk(0, 3, 44,  32'h0, 0, 0,  32'h0,        1, 1, 0, 0, 11, 32'h80ff5501, 32'h80ff7f01);
    vt[14] = mk(1, 4, 20,  32'hffffffff, 0, 0, 32'h0,  1, 1, 0, 0, 5,  32'hbeef3344, 32'h80ff7f01);
    vt[15] = mk(0, 5, 46,  32'h0, 0, 0,  32'h0,        3, 0, 0, 0, 11, 32'h80ff5501, 32'h000080ff);
    vt[16] = mk(0, 0, 44,  32'h0, 0, 0,  32'h0,        3, 0, 0, 0, 11, 32'h80ff5501, 32'h00000001);
    vt[17] = mk(0, 0, 45,  32'h0, 0, 0,  32'h0,        3, 0, 0, 0, 11, 32'h80ff5501, 32'h00000055);
    vt[18] = mk(0, 1, 45,  32'h0, 0, 0,  32'h0,        1, 1, 0, 0, 11, 32'h80ff5501, 32'h00000055);

    rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    pre_we = 1'b0; pre_a = 8'd0; pre_d = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset rdata", rdata, 32'd0);

    for (int i = 0; i < 19; i++) begin
      if (vt[i].pre_en) preload(vt[i].pre_idx, vt[i].pre_val);
      run(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, lat, nwe, wecyc, ma, e, bsy);
      chk($sformatf("v%0d latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d err", i), {31'd0, e}, {31'd0, vt[i].err});
      chk($sformatf("v%0d busy", i), {31'd0, bsy}, 32'd1);
      chk($sformatf("v%0d write count", i), nwe, vt[i].nwe);
      if (vt[i].nwe != 0) begin
        chk($sformatf("v%0d write cycle", i), wecyc, vt[i].wecyc);
        chk($sformatf("v%0d write addr", i), {24'd0, ma}, {24'd0, vt[i].midx});
      end
      chk($sformatf("v%0d mem", i), mem[vt[i].midx], vt[i].mval);
      chk($sformatf("v%0d rdata", i), rdata, vt[i].rdata);
    end

    // Reset during the MERGE cycle of a byte store must suppress the write.
    preload(8'd5, 32'h11223344);
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'd0; addr = 32'd20; wdata = 32'hdeadc0de;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("merge mem_we before rst", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("merge mem_we under rst", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("post-rst busy", {31'd0, busy}, 32'd0);
    chk("post-rst rdata", rdata, 32'd0);
    chk("post-rst mem", mem[5], 32'h11223344);
    e = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) e = 1'b1;
    end
    chk("post-rst no done", {31'd0, e}, 32'd0);
    run(1'b0, 3'd2, 32'd20, 32'd0, lat, nwe, wecyc, ma, e, bsy);
    chk("post-rst lw latency", lat, 3);
    chk("post-rst lw rdata", rdata, 32'h11223344);
    chk("post-rst lw err", {31'd0, e}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
